vga_timing_pipe: RTL and testbench

- Parametrised successor to the fixed 640x480 VGA timing generator and its hard-wired two-stage delay chain.
- Generates hcount/vcount, hsync/vsync and blank from one system clock, with a pixel clock-enable.
- Provides a configurable DELAY-stage aligned copy of all timing signals to match memory/LUT latency upstream of the VGA output registers.
- Adds frame/line strobes and a frame-boundary run/stop control.

---
 rtl/vga_timing_pipe.sv | 272 +++++++++++++++++++++++++++
 tb/tb_vga_timing_pipe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_pipe.sv
// Parametrised VGA timing generator with pixel clock-enable, frame-boundary run/stop and
// a DELAY-stage aligned copy of all timing signals. Optional colour-bar pattern: VGA_TIMING_PATTERN_EN.
module vga_timing_pipe #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 11,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 31,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int DELAY    = 2,
  parameter int HW       = 10,
  parameter int VW       = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pix_ce,
  input  logic          run,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic          line_start,
  output logic          frame_start,
  output logic [HW-1:0] del_hcount,
  output logic [VW-1:0] del_vcount,
  output logic          del_hsync,
  output logic          del_vsync,
  output logic          del_blank,
  output logic          active
`ifdef VGA_TIMING_PATTERN_EN
  ,
  output logic [7:0]    pat_red,
  output logic [7:0]    pat_green,
  output logic [7:0]    pat_blue
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PD      = (DELAY > 0) ? DELAY : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HS_ON  = 1'(HS_POL);
  localparam logic          VS_ON  = 1'(VS_POL);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Counter widths must hold the full line/frame length.
  if (H_TOTAL > (2 ** HW)) begin : g_bad_htotal
    $error("vga_timing_pipe: H_TOTAL does not fit in HW bits");
  end
  if (V_TOTAL > (2 ** VW)) begin : g_bad_vtotal
    $error("vga_timing_pipe: V_TOTAL does not fit in VW bits");
  end
  if (DELAY < 0 || DELAY > 8) begin : g_bad_delay
    $error("vga_timing_pipe: DELAY must be within 0..8");
  end

  logic [0:0]    state_r;
  logic [0:0]    state_n;
  logic [HW-1:0] h_n;
  logic [VW-1:0] v_n;
  logic          ls_n;
  logic          fs_n;
  logic          hs_n;
  logic          vs_n;
  logic          bl_n;

  // Next-state and next-counter evaluation; everything holds when pix_ce is low.
  always_comb begin
    state_n = state_r;
    h_n     = hcount;
    v_n     = vcount;
    ls_n    = 1'b0;
    fs_n    = 1'b0;
    if (pix_ce) begin
      case (state_r)
        ST_IDLE: begin
          h_n = {HW{1'b0}};
          v_n = {VW{1'b0}};
          if (run) begin
            state_n = ST_RUN;
            ls_n    = 1'b1;
            fs_n    = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (hcount == H_LAST) begin
            h_n = {HW{1'b0}};
            if (vcount == V_LAST) begin
              v_n = {VW{1'b0}};
              // Stop is honoured only here, so a dropped run always finishes the frame.
              if (run) begin
                ls_n = 1'b1;
                fs_n = 1'b1;
              end else begin
                state_n = ST_IDLE;
              end
            end else begin
              v_n  = vcount + VW'(1);
              ls_n = 1'b1;
            end
          end else begin
            h_n = hcount + HW'(1);
          end
        end
        default: begin
          state_n = ST_IDLE;
          h_n     = {HW{1'b0}};
          v_n     = {VW{1'b0}};
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Decode from the next counter values so registered syncs line up with the counters.
  always_comb begin
    hs_n = ~HS_ON;
    vs_n = ~VS_ON;
    if (state_n == ST_RUN) begin
      hs_n = ((h_n >= HS_BEG) && (h_n < HS_END)) ? HS_ON : ~HS_ON;
      vs_n = ((v_n >= VS_BEG) && (v_n < VS_END)) ? VS_ON : ~VS_ON;
    end else begin
      hs_n = ~HS_ON;
      vs_n = ~VS_ON;
    end
    bl_n = (h_n >= H_VIS) || (v_n >= V_VIS) || (state_n != ST_RUN);
  end

  // Undelayed timing registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      hcount      <= {HW{1'b0}};
      vcount      <= {VW{1'b0}};
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      blank       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state_r     <= state_n;
      hcount      <= h_n;
      vcount      <= v_n;
      hsync       <= hs_n;
      vsync       <= vs_n;
      blank       <= bl_n;
      line_start  <= ls_n;
      frame_start <= fs_n;
    end
  end

  assign active = (state_r == ST_RUN);

  logic [HW-1:0] pipe_h  [PD];
  logic [VW-1:0] pipe_v  [PD];
  logic          pipe_hs [PD];
  logic          pipe_vs [PD];
  logic          pipe_bl [PD];

  if (DELAY == 0) begin : g_nodelay
    assign del_hcount = hcount;
    assign del_vcount = vcount;
    assign del_hsync  = hsync;
    assign del_vsync  = vsync;
    assign del_blank  = blank;
  end else begin : g_pipe
    // Shift register over the registered timing signals; advances only on pix_ce.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < PD; i++) begin
          pipe_h[i]  <= {HW{1'b0}};
          pipe_v[i]  <= {VW{1'b0}};
          pipe_hs[i] <= ~HS_ON;
          pipe_vs[i] <= ~VS_ON;
          pipe_bl[i] <= 1'b1;
        end
      end else if (pix_ce) begin
        pipe_h[0]  <= hcount;
        pipe_v[0]  <= vcount;
        pipe_hs[0] <= hsync;
        pipe_vs[0] <= vsync;
        pipe_bl[0] <= blank;
        for (int i = 1; i < PD; i++) begin
          pipe_h[i]  <= pipe_h[i-1];
          pipe_v[i]  <= pipe_v[i-1];
          pipe_hs[i] <= pipe_hs[i-1];
          pipe_vs[i] <= pipe_vs[i-1];
          pipe_bl[i] <= pipe_bl[i-1];
        end
      end else begin
        pipe_h[0] <= pipe_h[0];
      end
    end
    assign del_hcount = pipe_h[PD-1];
    assign del_vcount = pipe_v[PD-1];
    assign del_hsync  = pipe_hs[PD-1];
    assign del_vsync  = pipe_vs[PD-1];
    assign del_blank  = pipe_bl[PD-1];
  end

`ifdef VGA_TIMING_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  function automatic logic [2:0] bar_rgb(input logic [HW-1:0] h);
    logic [2:0] bar;
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(h) >= k * BAR_W) bar = bar + 3'd1;
    end
    case (bar)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  endfunction

  // Values the del_* outputs take after this clock, so the pattern register lands aligned.
  logic [HW-1:0] dn_h;
  logic          dn_bl;
  logic [2:0]    rgb_n;

  if (DELAY == 0) begin : g_dn0
    assign dn_h  = h_n;
    assign dn_bl = bl_n;
  end else if (DELAY == 1) begin : g_dn1
    assign dn_h  = pix_ce ? hcount : del_hcount;
    assign dn_bl = pix_ce ? blank  : del_blank;
  end else begin : g_dnn
    assign dn_h  = pix_ce ? pipe_h[PD-2]  : del_hcount;
    assign dn_bl = pix_ce ? pipe_bl[PD-2] : del_blank;
  end

  assign rgb_n = dn_bl ? 3'b000 : bar_rgb(dn_h);

  // Colour-bar output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pat_red   <= 8'h00;
      pat_green <= 8'h00;
      pat_blue  <= 8'h00;
    end else begin
      pat_red   <= {8{rgb_n[2]}};
      pat_green <= {8{rgb_n[1]}};
      pat_blue  <= {8{rgb_n[0]}};
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Randomised self-checking bench for vga_timing_pipe against a position-based reference model
// (small timing so several frames fit; pattern checks compiled in with VGA_TIMING_PATTERN_EN).
module tb_vga_timing_pipe;
  localparam int HA = 16, HF = 2, HSW = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VSW = 2, VB = 2;
  localparam int HT = HA + HF + HSW + HB;   // 24
  localparam int VT = VA + VF + VSW + VB;   // 13
  localparam int FR = HT * VT;
  localparam int HP = 1, VP = 0, DL = 3;
  localparam int HW = 5, VW = 4;

  logic          clock = 1'b0;
  logic          reset, pix_ce, run;
  logic [HW-1:0] hcount, del_hcount;
  logic [VW-1:0] vcount, del_vcount;
  logic          hsync, vsync, blank, line_start, frame_start;
  logic          del_hsync, del_vsync, del_blank, active;
`ifdef VGA_TIMING_PATTERN_EN
  logic [7:0]    pat_red, pat_green, pat_blue;
`endif

  vga_timing_pipe #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .DELAY(DL), .HW(HW), .VW(VW)
  ) dut (
    .clock(clock), .reset(reset), .pix_ce(pix_ce), .run(run),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync), .blank(blank),
    .line_start(line_start), .frame_start(frame_start),
    .del_hcount(del_hcount), .del_vcount(del_vcount), .del_hsync(del_hsync),
    .del_vsync(del_vsync), .del_blank(del_blank), .active(active)
`ifdef VGA_TIMING_PATTERN_EN
    , .pat_red(pat_red), .pat_green(pat_green), .pat_blue(pat_blue)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", tag, $time);
  endtask

  // Reference model: a running flag and a linear position within the frame.
  typedef struct { int h; int v; bit hs; bit vs; bit bl; } tsig_t;
  bit    m_run;
  int    m_pos;
  bit    m_ls, m_fs;
  tsig_t hist[$];

  function automatic tsig_t cur_sig();
    tsig_t s;
    if (!m_run) begin
      s.h = 0; s.v = 0; s.hs = !HP; s.vs = !VP; s.bl = 1'b1;
    end else begin
      s.h  = m_pos % HT;
      s.v  = m_pos / HT;
      s.hs = (s.h >= HA + HF && s.h < HA + HF + HSW) ? 1'(HP) : !HP;
      s.vs = (s.v >= VA + VF && s.v < VA + VF + VSW) ? 1'(VP) : !VP;
      s.bl = (s.h >= HA) || (s.v >= VA);
    end
    return s;
  endfunction

  function automatic tsig_t del_sig();
    if (DL == 0) return cur_sig();
    return hist[0];
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_pos = 0; m_ls = 1'b0; m_fs = 1'b0;
    hist.delete();
    for (int i = 0; i < DL; i++) hist.push_back(cur_sig());
  endtask

  task automatic model_clock(input bit ce, input bit rq);
    tsig_t old;
    m_ls = 1'b0; m_fs = 1'b0;
    if (ce) begin
      old = cur_sig();
      if (DL > 0) begin
        hist.push_back(old);
        void'(hist.pop_front());
      end
      if (!m_run) begin
        if (rq) begin m_run = 1'b1; m_pos = 0; m_ls = 1'b1; m_fs = 1'b1; end
      end else if (m_pos == FR - 1 && !rq) begin
        m_run = 1'b0; m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % FR;
        m_ls  = (m_pos % HT) == 0;
        m_fs  = (m_pos == 0);
      end
    end
  endtask

  logic [2:0] bar_tab [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

  task automatic check_all();
    tsig_t s, d;
    logic [2:0] c;
    s = cur_sig();
    d = del_sig();
    check_eq("hcount", 32'(hcount), 32'(s.h));
    check_eq("vcount", 32'(vcount), 32'(s.v));
    check_eq("hsync", 32'(hsync), 32'(s.hs));
    check_eq("vsync", 32'(vsync), 32'(s.vs));
    check_eq("blank", 32'(blank), 32'(s.bl));
    check_eq("active", 32'(active), 32'(m_run));
    check_eq("line_start", 32'(line_start), 32'(m_ls));
    check_eq("frame_start", 32'(frame_start), 32'(m_fs));
    check_eq("del_hcount", 32'(del_hcount), 32'(d.h));
    check_eq("del_vcount", 32'(del_vcount), 32'(d.v));
    check_eq("del_hsync", 32'(del_hsync), 32'(d.hs));
    check_eq("del_vsync", 32'(del_vsync), 32'(d.vs));
    check_eq("del_blank", 32'(del_blank), 32'(d.bl));
`ifdef VGA_TIMING_PATTERN_EN
    c = d.bl ? 3'b000 : bar_tab[d.h / (HA / 8)];
    check_eq("pat_rgb", {8'h00, pat_red, pat_green, pat_blue},
             {8'h00, {8{c[2]}}, {8{c[1]}}, {8{c[0]}}});
`else
    c = 3'b000;
`endif
  endtask

  bit meas_en = 1'b0;
  int steps = 0, last_fs = -1, ls_cnt = 0;

  task automatic cyc(input bit ce, input bit rq);
    pix_ce = ce;
    run    = rq;
    @(posedge clock);
    model_clock(ce, rq);
    #1;
    check_all();
    if (ce) steps++;
    if (meas_en) begin
      if (frame_start) begin
        if (last_fs >= 0) begin
          check_eq("fs_period", 32'(steps - last_fs), 32'(FR));
          check_eq("ls_per_frame", 32'(ls_cnt), 32'(VT));
        end
        last_fs = steps;
        ls_cnt  = 0;
      end
      if (line_start) ls_cnt++;
    end
  endtask

  initial begin
    bit ok;
    bit rq;
    reset = 1'b1; pix_ce = 1'b0; run = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    model_reset();
    check_all();
    reset = 1'b0;

    // Continuous run with pix_ce every 4th clock: frame period and line-start count.
    meas_en = 1'b1;
    for (int i = 0; i < 4 * (2 * FR + 10); i++) cyc((i % 4) == 3, 1'b1);
    meas_en = 1'b0;

    // Fixed-lag delayed copy: del_hcount trails hcount by DL pix_ce steps.
    ok = 1'b0;
    for (int i = 0; i < 4 * FR && !ok; i++) begin
      cyc(1'b1, 1'b1);
      if (hcount == HW'(5) && vcount == VW'(2)) begin
        ok = 1'b1;
        check_eq("del_lag", 32'(del_hcount), 32'(5 - DL));
      end
    end
    if (!ok) timeout_fail("wait_h5");

    // Drop run mid-frame: the frame completes and stops silently at the wrap.
    ok = 1'b0;
    for (int i = 0; i < 4 * FR && !ok; i++) begin
      cyc(1'b1, 1'b1);
      ok = (hcount == HW'(3) && vcount == VW'(4));
    end
    if (!ok) timeout_fail("wait_drop_pos");
    ok = 1'b0;
    for (int i = 0; i < 2 * FR && !ok; i++) begin
      cyc($urandom_range(0, 1) == 1, 1'b0);
      ok = !active;
    end
    if (!ok) timeout_fail("wait_stop");
    check_eq("stop_h", 32'(hcount), 32'd0);
    check_eq("stop_blank", 32'(blank), 32'd1);
    check_eq("stop_no_fs", 32'(frame_start), 32'd0);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    check_eq("restart_fs", 32'(frame_start), 32'd1);

    // Randomised pix_ce and occasional run toggles.
    rq = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 199) == 0) rq = !rq;
      cyc($urandom_range(0, 2) != 0, rq);
    end

    // Asynchronous reset mid-line takes effect without waiting for a clock edge.
    ok = 1'b0;
    for (int i = 0; i < 4 * FR && !ok; i++) begin
      cyc(1'b1, 1'b1);
      ok = (hcount == HW'(10));
    end
    if (!ok) timeout_fail("wait_h10");
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    check_eq("rst_hsync", 32'(hsync), 32'(!HP));
    check_eq("rst_del_blank", 32'(del_blank), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3 * FR; i++) cyc($urandom_range(0, 3) != 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
